// File: rtl/uart_pkg.sv
// uart_pkg: shared parity codes, FSM state types and divisor floor for the UART core
// Contents:
//   PAR_NONE/PAR_EVEN/PAR_ODD  parity_mode encodings (3 behaves as none)
//   MIN_DIV                    smallest usable clocks-per-bit
//   tx_state_e, rx_state_e     transmitter / receiver FSM states
//   par_en()                   true when a parity bit is sent / checked
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  localparam int MIN_DIV = 2;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;
  function automatic logic par_en(input logic [1:0] m);
    return m == PAR_EVEN || m == PAR_ODD;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter, ticks while the count sits at zero
// Ports:
//   clk_i, rst_ni   clock and synchronous active-low reset
//   load_i          reload the counter with load_value_i this cycle
//   load_value_i    reload value (period minus one)
//   tick_o          count is zero; the owner reloads on this to start the next period
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_value_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_value_i : (cnt_q != '0) ? cnt_q - DIV_W'(1) : cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign tick_o = cnt_q == '0;
endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART with runtime divisor, optional parity and 1/2 stop bits
// Ports:
//   sys_clk, sys_rst_n         clock and synchronous active-low reset
//   divisor                    clocks per bit (values below 2 act as 2), latched per frame
//   parity_mode, two_stop      frame format, latched per frame
//   tx_data/tx_valid/tx_ready  transmit word handshake
//   tx                         serial output, idles high
//   rx                         asynchronous serial input
//   rx_data/rx_valid/rx_ready  receive word handshake
//   rx_frame_err/rx_parity_err status held with rx_data while rx_valid
//   rx_overrun                 one-cycle pulse when a finished word is dropped
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [DIV_W-1:0] div_c;
  assign div_c = (divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divisor;
  tx_state_e tx_st_q, tx_st_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [DIV_W-1:0] tx_div_q, tx_div_d, tx_ldv;
  logic tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_two_q, tx_two_d;
  logic tx_q, tx_d, tx_ld, tx_tick;
  uart_bit_timer #(.DIV_W(DIV_W)) u_tx_timer (
    .clk_i(sys_clk), .rst_ni(sys_rst_n), .load_i(tx_ld), .load_value_i(tx_ldv), .tick_o(tx_tick)
  );
  // tx is registered from the next state so the pin changes on the same edge as the FSM
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_sh_d  = tx_sh_q;
    tx_cnt_d = tx_cnt_q;
    tx_div_d = tx_div_q;
    tx_par_d = tx_par_q;
    tx_pen_d = tx_pen_q;
    tx_two_d = tx_two_q;
    tx_ld    = 1'b0;
    tx_ldv   = tx_div_q - DIV_W'(1);
    case (tx_st_q)
      TX_IDLE: if (tx_valid) begin
        tx_st_d  = TX_START;
        tx_sh_d  = tx_data;
        tx_div_d = div_c;
        tx_par_d = ^tx_data ^ (parity_mode == PAR_ODD);
        tx_pen_d = par_en(parity_mode);
        tx_two_d = two_stop;
        tx_ld    = 1'b1;
        tx_ldv   = div_c - DIV_W'(1);
      end
      TX_START: if (tx_tick) begin
        tx_st_d  = TX_DATA;
        tx_cnt_d = '0;
        tx_ld    = 1'b1;
      end
      TX_DATA: if (tx_tick) begin
        tx_ld    = 1'b1;
        tx_sh_d  = tx_sh_q >> 1;
        tx_cnt_d = tx_cnt_q + CW'(1);
        if (tx_cnt_q == CW'(DATA_W - 1)) tx_st_d = tx_pen_q ? TX_PARITY : TX_STOP1;
      end
      TX_PARITY: if (tx_tick) begin
        tx_ld   = 1'b1;
        tx_st_d = TX_STOP1;
      end
      TX_STOP1: if (tx_tick) begin
        tx_ld   = 1'b1;
        tx_st_d = tx_two_q ? TX_STOP2 : TX_IDLE;
      end
      TX_STOP2: if (tx_tick) tx_st_d = TX_IDLE;
      default: tx_st_d = TX_IDLE;
    endcase
    tx_d = (tx_st_d == TX_START) ? 1'b0 :
           (tx_st_d == TX_DATA) ? tx_sh_d[0] :
           (tx_st_d == TX_PARITY) ? tx_par_q : 1'b1;
  end
  assign tx_ready = tx_st_q == TX_IDLE;
  assign tx = tx_q;
  rx_state_e rx_st_q, rx_st_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [DIV_W-1:0] rx_div_q, rx_div_d, rx_ldv;
  logic rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
  logic rx_valid_q, rx_valid_d, rx_fe_q, rx_fe_d, rx_pe_q, rx_pe_d, rx_ovr_q, rx_ovr_d;
  logic s1_q, s2_q, rxs, rx_ld, rx_tick;
  assign rxs = s2_q;
  uart_bit_timer #(.DIV_W(DIV_W)) u_rx_timer (
    .clk_i(sys_clk), .rst_ni(sys_rst_n), .load_i(rx_ld), .load_value_i(rx_ldv), .tick_o(rx_tick)
  );
  // the start bit is re-checked half a bit after the falling edge, which also centres later samples
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_sh_d    = rx_sh_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_pen_d   = rx_pen_q;
    rx_odd_d   = rx_odd_q;
    rx_perr_d  = rx_perr_q;
    rx_data_d  = rx_data_q;
    rx_fe_d    = rx_fe_q;
    rx_pe_d    = rx_pe_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    rx_ovr_d   = 1'b0;
    rx_ld      = 1'b0;
    rx_ldv     = rx_div_q - DIV_W'(1);
    case (rx_st_q)
      RX_IDLE: if (!rxs) begin
        rx_st_d   = RX_START;
        rx_div_d  = div_c;
        rx_pen_d  = par_en(parity_mode);
        rx_odd_d  = parity_mode == PAR_ODD;
        rx_perr_d = 1'b0;
        rx_ld     = 1'b1;
        rx_ldv    = (div_c >> 1) - DIV_W'(1);
      end
      RX_START: if (rx_tick) begin
        if (rxs) rx_st_d = RX_IDLE;
        else begin
          rx_st_d  = RX_DATA;
          rx_cnt_d = '0;
          rx_ld    = 1'b1;
        end
      end
      RX_DATA: if (rx_tick) begin
        rx_ld    = 1'b1;
        rx_sh_d  = {rxs, rx_sh_q[DATA_W-1:1]};
        rx_cnt_d = rx_cnt_q + CW'(1);
        if (rx_cnt_q == CW'(DATA_W - 1)) rx_st_d = rx_pen_q ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_tick) begin
        rx_ld     = 1'b1;
        rx_perr_d = ^rx_sh_q ^ rxs ^ rx_odd_q;
        rx_st_d   = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_st_d = rxs ? RX_IDLE : RX_BREAK;
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = rx_sh_q;
          rx_fe_d    = !rxs;
          rx_pe_d    = rx_perr_q;
          rx_valid_d = 1'b1;
        end else rx_ovr_d = 1'b1;
      end
      RX_BREAK: if (rxs) rx_st_d = RX_IDLE;
      default: rx_st_d = RX_IDLE;
    endcase
  end
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_fe_q;
  assign rx_parity_err = rx_pe_q;
  assign rx_overrun    = rx_ovr_q;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      tx_st_q    <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_W'(MIN_DIV);
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_two_q   <= 1'b0;
      tx_q       <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_sh_q    <= '0;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_W'(MIN_DIV);
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_ovr_q   <= 1'b0;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_par_q   <= tx_par_d;
      tx_pen_q   <= tx_pen_d;
      tx_two_q   <= tx_two_d;
      tx_q       <= tx_d;
      rx_st_q    <= rx_st_d;
      rx_sh_q    <= rx_sh_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_pen_q   <= rx_pen_d;
      rx_odd_q   <= rx_odd_d;
      rx_perr_q  <= rx_perr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_fe_q    <= rx_fe_d;
      rx_pe_q    <= rx_pe_d;
      rx_ovr_q   <= rx_ovr_d;
      s1_q       <= rx;
      s2_q       <= s1_q;
    end
  end
endmodule
